// File: rtl/uart_cmd_rx_if.sv
// Command-receiver signal bundle: serial line and downstream handshake in, command and status out.
// master drives the line (source side), slave is the receiver.
interface uart_cmd_rx_if;
   logic       rx_serial;
   logic       ready_to_act;
   logic [7:0] uart_rx;
   logic       valid_command;
   logic       frame_error;
   logic       cmd_dropped;

   modport master (
      output rx_serial,
      output ready_to_act,
      input  uart_rx,
      input  valid_command,
      input  frame_error,
      input  cmd_dropped
   );

   modport slave (
      input  rx_serial,
      input  ready_to_act,
      output uart_rx,
      output valid_command,
      output frame_error,
      output cmd_dropped
   );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that accepts only the command bytes "T" and "D" and hands them downstream
// when the crossbar is idle; all status outputs are single-cycle registered pulses.
module uart_cmd_rx #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input logic          clk,
   input logic          rst,
   uart_cmd_rx_if.slave bus
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned TW           = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HalfTick   = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] LastTick   = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StCheck} state_e;

   state_e        state_q;
   logic [1:0]    sync_q;
   logic [1:0]    settle_q;
   logic          armed_q;
   logic [TW-1:0] timer_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic [7:0]    uart_rx_q;
   logic          valid_q;
   logic          ferr_q;
   logic          drop_q;
   logic          rx;

   assign rx = sync_q[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         sync_q    <= 2'b11;
         settle_q  <= 2'b00;
         armed_q   <= 1'b0;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         uart_rx_q <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], bus.rx_serial};
         settle_q <= {settle_q[0], 1'b1};
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         drop_q   <= 1'b0;
         // The synchronizer resets to 1, so only trust a high line once real samples reach it;
         // a start edge that began during reset is ignored until the line returns high.
         if (settle_q[1] && rx) armed_q <= 1'b1;

         unique case (state_q)
            StIdle: begin
               if (armed_q && !rx) begin
                  state_q <= StStart;
                  timer_q <= '0;
               end
            end
            StStart: begin
               if (timer_q == HalfTick) begin
                  if (rx) begin
                     state_q <= StIdle;
                  end else begin
                     state_q   <= StData;
                     timer_q   <= '0;
                     bit_idx_q <= '0;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            StData: begin
               if (timer_q == LastTick) begin
                  timer_q            <= '0;
                  shift_q[bit_idx_q] <= rx;
                  if (bit_idx_q == 3'd7) state_q <= StStop;
                  else                   bit_idx_q <= bit_idx_q + 3'd1;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            StStop: begin
               if (timer_q == LastTick) begin
                  timer_q <= '0;
                  if (rx) begin
                     state_q <= StCheck;
                  end else begin
                     ferr_q  <= 1'b1;
                     shift_q <= '0;
                     state_q <= StIdle;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            StCheck: begin
               if (shift_q == 8'h54 || shift_q == 8'h44) begin
                  if (bus.ready_to_act) begin
                     uart_rx_q <= shift_q;
                     valid_q   <= 1'b1;
                  end else begin
                     drop_q <= 1'b1;
                  end
               end
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.uart_rx       = uart_rx_q;
   assign bus.valid_command = valid_q;
   assign bus.frame_error   = ferr_q;
   assign bus.cmd_dropped   = drop_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomized bench for uart_cmd_rx: frames are built bit by bit and the expected outcome of each
// frame is derived from the byte, stop bit and ready level alone.
module tb_uart_cmd_rx;

   localparam int CPB = 10;
   // sync (2) + idle detect (1), half bit to start sample, 9 bits to stop sample, CHECK (1)
   localparam int LAT = 3 + CPB / 2 + 9 * CPB + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;

   uart_cmd_rx_if bus ();

   uart_cmd_rx #(
      .CLK_FREQ(1_000_000),
      .BAUD    (100_000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   int n_valid = 0, n_ferr = 0, n_drop = 0, onehot_viol = 0, valid_cyc = 0;
   int exp_valid = 0, exp_ferr = 0, exp_drop = 0;
   logic [7:0] exp_rx = 8'h00;
   logic [7:0] got_bytes[$];
   logic [7:0] exp_bytes[$];

   always @(negedge clk) begin
      if (bus.valid_command) begin
         n_valid++;
         got_bytes.push_back(bus.uart_rx);
         valid_cyc = cyc;
      end
      if (bus.frame_error) n_ferr++;
      if (bus.cmd_dropped) n_drop++;
      if (int'(bus.valid_command) + int'(bus.frame_error) + int'(bus.cmd_dropped) > 1)
         onehot_viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle(input int n);
      bus.rx_serial = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v);
      bus.rx_serial = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic check_rst_outs();
      check("rst_outs", {21'h0, bus.uart_rx, bus.valid_command, bus.frame_error, bus.cmd_dropped},
            32'h0);
   endtask

   // Caller must be positioned just after a rising edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_at_bit,
                             output int start);
      start = cyc;
      drive(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == rst_at_bit) begin
            bus.rx_serial = b[i];
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            check_rst_outs();
            repeat (CPB - 3) @(posedge clk);
            #1;
         end else begin
            drive(b[i]);
         end
      end
      drive(stop_bit);
      if (rst_at_bit >= 0) rst = 1'b1;
   endtask

   task automatic compare_state();
      check("valid_cnt", n_valid, exp_valid);
      check("ferr_cnt", n_ferr, exp_ferr);
      check("drop_cnt", n_drop, exp_drop);
      check("uart_rx", {24'h0, bus.uart_rx}, {24'h0, exp_rx});
      check("byte_q_len", got_bytes.size(), exp_bytes.size());
      while (got_bytes.size() > 0 && exp_bytes.size() > 0)
         check("cmd_byte", {24'h0, got_bytes.pop_front()}, {24'h0, exp_bytes.pop_front()});
   endtask

   task automatic expect_frame(input logic [7:0] b, input logic stop_ok, input logic ready,
                               input int start);
      logic expect_valid;
      expect_valid = 1'b0;
      if (!stop_ok) begin
         exp_ferr++;
      end else if (b == 8'h54 || b == 8'h44) begin
         if (ready) begin
            exp_valid++;
            exp_rx = b;
            exp_bytes.push_back(b);
            expect_valid = 1'b1;
         end else begin
            exp_drop++;
         end
      end
      compare_state();
      if (expect_valid) check("latency", valid_cyc - start, LAT);
   endtask

   task automatic frame(input logic [7:0] b, input logic stop_ok, input logic ready);
      int start;
      bus.ready_to_act = ready;
      send_frame(b, stop_ok, -1, start);
      expect_frame(b, stop_ok, ready, start);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int start;
      bus.rx_serial    = 1'b1;
      bus.ready_to_act = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_rst_outs();
      rst = 1'b1;
      idle(20);

      frame(8'h54, 1'b1, 1'b1);
      frame(8'h44, 1'b1, 1'b1);
      frame(8'h54, 1'b1, 1'b1);
      idle(5);
      frame(8'h41, 1'b1, 1'b1);
      idle(5);
      frame(8'h54, 1'b0, 1'b1);
      idle(CPB);
      frame(8'h44, 1'b1, 1'b0);
      idle(5);

      // Short low glitch: false start, no pulses
      bus.rx_serial = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(30);
      compare_state();

      // Reset during data bit 4 aborts the frame and clears uart_rx
      bus.ready_to_act = 1'b1;
      send_frame(8'h54, 1'b1, 4, start);
      exp_rx = 8'h00;
      idle(20);
      compare_state();
      frame(8'h54, 1'b1, 1'b1);
      idle(5);

      // Reset released while the line is already low: ignored until the line goes high
      rst = 1'b0;
      bus.rx_serial = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      exp_rx = 8'h00;
      rst = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      idle(30);
      compare_state();
      frame(8'h54, 1'b1, 1'b1);
      idle(5);

      // Break: line held low gives a frame_error every frame period
      bus.rx_serial = 1'b0;
      repeat (295) @(posedge clk);
      #1;
      exp_ferr += 3;
      idle(250);
      compare_state();

      for (int k = 0; k < 30; k++) begin
         logic [7:0] b;
         logic       ready;
         logic       stop_ok;
         int         sel;
         sel = $urandom_range(0, 3);
         b = (sel == 0) ? 8'h54 : (sel == 1) ? 8'h44 : 8'($urandom);
         ready = ($urandom_range(0, 3) != 0);
         stop_ok = ($urandom_range(0, 5) != 0);
         frame(b, stop_ok, ready);
         if (!stop_ok) idle(CPB);
         else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 25));
      end
      idle(20);
      compare_state();
      check("onehot_viol", onehot_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
